// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: processor M-stage vs. buffered external requests.
// Optional round-robin NORMAL-state arbitration via `define DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           proc_req_val,
  input  logic                           proc_req_type,
  input  logic [31:0]                    proc_req_addr,
  input  logic [31:0]                    proc_req_wdata,
  output logic [31:0]                    proc_resp_rdata,
  output logic                           proc_stall,
  input  logic                           ext_req_val,
  output logic                           ext_req_rdy,
  input  logic                           ext_req_type,
  input  logic [31:0]                    ext_req_addr,
  input  logic [31:0]                    ext_req_wdata,
  output logic                           ext_resp_val,
  output logic [31:0]                    ext_resp_rdata,
  output logic                           mem_req_val,
  output logic                           mem_req_type,
  output logic [31:0]                    mem_req_addr,
  output logic [31:0]                    mem_req_wdata,
  input  logic [31:0]                    mem_resp_rdata,
  output logic [$clog2(DEPTH+1)-1:0]     ext_q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);

  typedef enum logic {NORMAL, STARVED} state_t;

  logic          q_type  [DEPTH];
  logic [31:0]   q_addr  [DEPTH];
  logic [31:0]   q_wdata [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt, starve_next;
  state_t        state;

  logic empty, full, push, pop, ext_grant, starved;
  logic head_type;
  logic [31:0] head_addr, head_wdata;

  assign empty       = (ext_q_count == '0);
  assign full        = (ext_q_count == CW'(DEPTH));
  assign ext_req_rdy = !full;
  assign push        = ext_req_val && ext_req_rdy;
  assign pop         = ext_grant;

  assign head_type  = q_type[rd_ptr];
  assign head_addr  = q_addr[rd_ptr];
  assign head_wdata = q_wdata[rd_ptr];

  assign starved = (state == STARVED) && !empty;

`ifdef DMEM_ARB_RR_EN
  logic last_grant;  // 0 = processor, 1 = external

  assign ext_grant = starved || (!empty && (!proc_req_val || !last_grant));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b0;
    end else if (ext_grant) begin
      last_grant <= 1'b1;
    end else if (proc_req_val) begin
      last_grant <= 1'b0;
    end
  end
`else
  assign ext_grant = starved || (!empty && !proc_req_val);
`endif

  assign proc_stall      = proc_req_val && ext_grant;
  assign proc_resp_rdata = mem_resp_rdata;

  always_comb begin
    mem_req_val   = proc_req_val || ext_grant;
    mem_req_type  = proc_req_type;
    mem_req_addr  = proc_req_addr;
    mem_req_wdata = proc_req_wdata;
    if (ext_grant) begin
      mem_req_type  = head_type;
      mem_req_addr  = head_addr;
      mem_req_wdata = head_wdata;
    end else if (!proc_req_val) begin
      mem_req_type  = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
    end
  end

  always_comb begin
    starve_next = starve_cnt;
    if (empty || ext_grant) begin
      starve_next = '0;
    end else if (starve_cnt != SW'(MAX_WAIT)) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  // Storage is not reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_type[wr_ptr]  <= ext_req_type;
      q_addr[wr_ptr]  <= ext_req_addr;
      q_wdata[wr_ptr] <= ext_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ext_q_count    <= '0;
      starve_cnt     <= '0;
      state          <= NORMAL;
      ext_resp_val   <= 1'b0;
      ext_resp_rdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   ext_q_count <= ext_q_count + 1'b1;
        2'b01:   ext_q_count <= ext_q_count - 1'b1;
        default: ext_q_count <= ext_q_count;
      endcase
      starve_cnt <= starve_next;
      state      <= (starve_next == SW'(MAX_WAIT)) ? STARVED : NORMAL;
      ext_resp_val <= ext_grant;
      if (ext_grant) begin
        ext_resp_rdata <= head_type ? '0 : mem_resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural memory, expected external
// responses queued at enqueue time and checked as they emerge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        proc_req_val, proc_req_type;
  logic [31:0] proc_req_addr, proc_req_wdata, proc_resp_rdata;
  logic        proc_stall;
  logic        ext_req_val, ext_req_rdy, ext_req_type;
  logic [31:0] ext_req_addr, ext_req_wdata;
  logic        ext_resp_val;
  logic [31:0] ext_resp_rdata;
  logic        mem_req_val, mem_req_type;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [2:0]  ext_q_count;

  logic [31:0] mem_model [256];
  logic [31:0] shadow    [256];
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .proc_req_val(proc_req_val), .proc_req_type(proc_req_type),
    .proc_req_addr(proc_req_addr), .proc_req_wdata(proc_req_wdata),
    .proc_resp_rdata(proc_resp_rdata), .proc_stall(proc_stall),
    .ext_req_val(ext_req_val), .ext_req_rdy(ext_req_rdy),
    .ext_req_type(ext_req_type), .ext_req_addr(ext_req_addr),
    .ext_req_wdata(ext_req_wdata), .ext_resp_val(ext_resp_val),
    .ext_resp_rdata(ext_resp_rdata), .mem_req_val(mem_req_val),
    .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_rdata(mem_resp_rdata),
    .ext_q_count(ext_q_count)
  );

  always #5 clk = ~clk;

  assign mem_resp_rdata = mem_model[mem_req_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req_val && mem_req_type) mem_model[mem_req_addr[9:2]] <= mem_req_wdata;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && ext_resp_val === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ext_resp_unexpected got rdata=%h, required no response", ext_resp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ext_resp_rdata !== mon_exp) begin
          fails++;
          $display("FAIL ext_resp_rdata got %h required %h", ext_resp_rdata, mon_exp);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one external request for one cycle; returns just after the capturing edge.
  task automatic ext_push(input logic t, input logic [31:0] a, input logic [31:0] d);
    ext_req_type  = t;
    ext_req_addr  = a;
    ext_req_wdata = d;
    ext_req_val   = 1'b1;
    #1;
    tests++;
    if (ext_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL ext_push_rdy got %b required 1", ext_req_rdy);
    end else if (t) begin
      exp_q.push_back(32'h0);
      shadow[a[9:2]] = d;
    end else begin
      exp_q.push_back(shadow[a[9:2]]);
    end
    next_cycle();
    ext_req_val = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    proc_req_val = 1'b1; proc_req_type = 1'b0;
    proc_req_addr = 32'h200; proc_req_wdata = 32'h0;
    ext_req_val = 1'b0; ext_req_type = 1'b0;
    ext_req_addr = 32'h0; ext_req_wdata = 32'h0;
    #2;
    tests++;
    if (ext_req_rdy !== 1'b1 || proc_stall !== 1'b0 || mem_req_val !== 1'b1) begin
      fails++;
      $display("FAIL reset_comb got rdy=%b stall=%b mval=%b required 1 0 1",
               ext_req_rdy, proc_stall, mem_req_val);
    end
    tests++;
    if (ext_q_count !== 3'd0 || ext_resp_val !== 1'b0 || ext_resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_regs got cnt=%0d rval=%b rdata=%h required 0 0 0",
               ext_q_count, ext_resp_val, ext_resp_rdata);
    end
    proc_req_val = 1'b0;
    #1;
    tests++;
    if (mem_req_val !== 1'b0) begin
      fails++;
      $display("FAIL reset_mval_idle got %b required 0", mem_req_val);
    end
    @(negedge clk) rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_ext_write();
    ext_push(1'b1, 32'h100, 32'hDEADBEEF);
    #1;
    tests++;
    if (mem_req_val !== 1'b1 || mem_req_type !== 1'b1 || mem_req_addr !== 32'h100 ||
        mem_req_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL ext_write_grant got val=%b type=%b addr=%h wdata=%h required 1 1 100 deadbeef",
               mem_req_val, mem_req_type, mem_req_addr, mem_req_wdata);
    end
    tests++;
    if (ext_q_count !== 3'd1 || proc_stall !== 1'b0) begin
      fails++;
      $display("FAIL ext_write_count got cnt=%0d stall=%b required 1 0", ext_q_count, proc_stall);
    end
    next_cycle();
    tests++;
    if (ext_resp_val !== 1'b1 || ext_q_count !== 3'd0 || mem_req_val !== 1'b0) begin
      fails++;
      $display("FAIL ext_write_resp got rval=%b cnt=%0d mval=%b required 1 0 0",
               ext_resp_val, ext_q_count, mem_req_val);
    end
    next_cycle();
  endtask

  task automatic test_ext_read();
    ext_push(1'b0, 32'h100, 32'h0);
    #1;
    tests++;
    if (mem_req_val !== 1'b1 || mem_req_type !== 1'b0 || mem_req_addr !== 32'h100) begin
      fails++;
      $display("FAIL ext_read_grant got val=%b type=%b addr=%h required 1 0 100",
               mem_req_val, mem_req_type, mem_req_addr);
    end
    next_cycle();
    tests++;
    if (ext_resp_val !== 1'b1 || ext_resp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL ext_read_resp got rval=%b rdata=%h required 1 deadbeef",
               ext_resp_val, ext_resp_rdata);
    end
    next_cycle();
    tests++;
    if (ext_resp_val !== 1'b0 || ext_resp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL ext_read_pulse got rval=%b rdata=%h required 0 deadbeef",
               ext_resp_val, ext_resp_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_stall;
    proc_req_val = 1'b1; proc_req_type = 1'b0; proc_req_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      ext_push(1'b1, 32'h10 + 32'(4 * i), 32'hA500_0000 + 32'(i));
      #1;
      tests++;
      if (proc_stall !== 1'b0 || mem_req_addr !== 32'h200) begin
        fails++;
        $display("FAIL fill_proc_wins got stall=%b addr=%h required 0 200", proc_stall, mem_req_addr);
      end
    end
    tests++;
    if (ext_req_rdy !== 1'b0 || ext_q_count !== 3'd4) begin
      fails++;
      $display("FAIL fill_full got rdy=%b cnt=%0d required 0 4", ext_req_rdy, ext_q_count);
    end
    tests++;
    if (proc_resp_rdata !== shadow[8'h80]) begin
      fails++;
      $display("FAIL proc_rdata got %h required %h", proc_resp_rdata, shadow[8'h80]);
    end
    for (int cyc = 4; cyc <= 36; cyc++) begin
      if (cyc > 4) begin
        next_cycle();
        #1;
      end
      exp_stall = (cyc % 9 == 0);
      tests++;
      if (proc_stall !== exp_stall) begin
        fails++;
        $display("FAIL starve_stall cycle %0d got %b required %b", cyc, proc_stall, exp_stall);
      end
      if (exp_stall) begin
        tests++;
        if (mem_req_addr !== 32'h10 + 32'(4 * (cyc / 9 - 1)) || mem_req_type !== 1'b1) begin
          fails++;
          $display("FAIL starve_head cycle %0d got addr=%h type=%b required %h 1",
                   cyc, mem_req_addr, mem_req_type, 32'h10 + 32'(4 * (cyc / 9 - 1)));
        end
      end
    end
    next_cycle();
    #1;
    tests++;
    if (ext_q_count !== 3'd0 || proc_stall !== 1'b0 || ext_req_rdy !== 1'b1) begin
      fails++;
      $display("FAIL starve_drained got cnt=%0d stall=%b rdy=%b required 0 0 1",
               ext_q_count, proc_stall, ext_req_rdy);
    end
    proc_req_val = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    proc_req_val = 1'b0;
    ext_push(1'b0, 32'h100, 32'h0);
    next_cycle();
    proc_req_val = 1'b1;
    for (int i = 0; i < 3; i++) ext_push(1'b0, 32'h10 + 32'(4 * i), 32'h0);
    #2;
    tests++;
    if (ext_q_count !== 3'd3 || ext_resp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL pre_reset got cnt=%0d rdata=%h required 3 deadbeef", ext_q_count, ext_resp_rdata);
    end
    rst = 1'b0;
    #1;
    exp_q.delete();
    tests++;
    if (ext_q_count !== 3'd0 || ext_req_rdy !== 1'b1 || proc_stall !== 1'b0 ||
        mem_req_val !== 1'b1 || mem_req_addr !== 32'h200) begin
      fails++;
      $display("FAIL async_reset_comb got cnt=%0d rdy=%b stall=%b mval=%b addr=%h required 0 1 0 1 200",
               ext_q_count, ext_req_rdy, proc_stall, mem_req_val, mem_req_addr);
    end
    tests++;
    if (ext_resp_val !== 1'b0 || ext_resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL async_reset_resp got rval=%b rdata=%h required 0 0", ext_resp_val, ext_resp_rdata);
    end
    @(negedge clk) rst = 1'b1;
    proc_req_val = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      tests++;
      if (ext_resp_val !== 1'b0 || ext_q_count !== 3'd0 || mem_req_val !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle cycle %0d got rval=%b cnt=%0d mval=%b required 0 0 0",
                 i, ext_resp_val, ext_q_count, mem_req_val);
      end
    end
  endtask

`ifdef DMEM_ARB_RR_EN
  task automatic test_rr();
    logic exp_stall;
    proc_req_val = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc <= 3) ext_push(1'b0, 32'h10 + 32'(4 * (cyc - 1)), 32'h0);
      else next_cycle();
      #1;
      exp_stall = (cyc % 2 == 1) && (cyc <= 5);
      tests++;
      if (proc_stall !== exp_stall) begin
        fails++;
        $display("FAIL rr_alternate cycle %0d got stall=%b required %b", cyc, proc_stall, exp_stall);
      end
    end
    proc_req_val = 1'b0;
    next_cycle();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = 32'h1357_0000 ^ (32'(i) * 32'h0101_0101);
      shadow[i]    = 32'h1357_0000 ^ (32'(i) * 32'h0101_0101);
    end
    test_reset();
    test_ext_write();
    test_ext_read();
`ifdef DMEM_ARB_RR_EN
    test_reset_mid();
    test_rr();
`else
    test_starvation();
    test_reset_mid();
`endif
    repeat (4) next_cycle();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
